// File: rtl/atan_poly_pkg.sv
// ============================================================================
// atan_poly_pkg : widths, Q-format shifts and minimax coefficients for atan_poly
// Revision      : 1.0
// ============================================================================
`default_nettype none

package atan_poly_pkg;

  localparam int IN_W  = 8;   // x, signed Q1.7
  localparam int OUT_W = 16;  // atan(x), signed Q1.15 radians
  localparam int LAT   = 4;   // fixed pipeline depth

  localparam int S_W   = 16;  // x^2, unsigned-valued Q2.14
  localparam int T_W   = 17;  // Horner partial sums, signed
  localparam int C_W   = 16;  // coefficient width, signed Q1.15

  localparam int SH_S  = 14;  // rescale after multiplying by x^2
  localparam int SH_X  = 7;   // rescale after multiplying by x

  localparam logic signed [C_W-1:0] C1 = 16'sd32616;
  localparam logic signed [C_W-1:0] C3 = -16'sd9459;
  localparam logic signed [C_W-1:0] C5 = 16'sd2600;

endpackage

`default_nettype wire

// File: rtl/atan_poly_mac.sv
// ============================================================================
// atan_poly_mac : registered acc = C_VAL + ((a*s) >>> SH), valid passes through
// Config        : ATAN_POLY_ROUND_EN adds 2^(SH-1) before the shift
// Revision      : 1.0
// ============================================================================
`default_nettype none

module atan_poly_mac
  import atan_poly_pkg::*;
#(
  parameter int                      A_W   = 16,
  parameter int                      SH    = 14,
  parameter logic signed [C_W-1:0]   C_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  val_i,
  input  logic signed [A_W-1:0] a_i,
  input  logic [S_W-1:0]        s_i,
  output logic                  val_o,
  output logic signed [T_W-1:0] acc_o
);

  localparam int P_W = A_W + S_W + 1;

`ifdef ATAN_POLY_ROUND_EN
  localparam logic signed [P_W-1:0] RND = P_W'(1) << (SH - 1);
`else
  localparam logic signed [P_W-1:0] RND = '0;
`endif

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] s_ext;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] shifted;
  logic signed [P_W-1:0] sum;
  logic signed [T_W-1:0] acc_d;
  logic signed [T_W-1:0] acc_q;
  logic                  val_q;
  logic                  unused_sum_hi;

  // s is unsigned-valued, so it is zero-extended before the signed multiply
  assign a_ext   = P_W'(a_i);
  assign s_ext   = P_W'({1'b0, s_i});
  assign prod    = a_ext * s_ext;
  assign shifted = (prod + RND) >>> SH;
  assign sum     = P_W'(C_VAL) + shifted;
  assign acc_d   = sum[T_W-1:0];

  assign unused_sum_hi = ^sum[P_W-1:T_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      val_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      val_q <= val_i;
    end
  end

  assign acc_o = acc_q;
  assign val_o = val_q;

endmodule

`default_nettype wire

// File: rtl/atan_poly.sv
// ============================================================================
// atan_poly : 4-stage pipelined atan(x) ~= x*(C1 + C3*x^2 + C5*x^4), Q1.7 -> Q1.15
// Config    : ATAN_POLY_ROUND_EN selects round-half-up instead of floor shifts
// Revision  : 1.0
// ============================================================================
`default_nettype none

module atan_poly
  import atan_poly_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             val_i,
  input  logic [IN_W-1:0]  atan_poly_i,
  output logic             val_o,
  output logic [OUT_W-1:0] atan_poly_o
);

  localparam int Y_W = T_W + IN_W;

`ifdef ATAN_POLY_ROUND_EN
  localparam logic signed [Y_W-1:0] Y_RND = Y_W'(1) << (SH_X - 1);
`else
  localparam logic signed [Y_W-1:0] Y_RND = '0;
`endif

  logic signed [S_W-1:0]  x_ext;
  logic signed [S_W-1:0]  sq;
  logic [S_W-1:0]         s1_q;
  logic [S_W-1:0]         s2_q;
  logic [IN_W-1:0]        x1_q;
  logic [IN_W-1:0]        x2_q;
  logic [IN_W-1:0]        x3_q;
  logic                   v1_q;
  logic                   v2;
  logic                   v3;
  logic                   val_o_q;
  logic signed [T_W-1:0]  t2;
  logic signed [T_W-1:0]  t3;
  logic signed [Y_W-1:0]  y_prod;
  logic signed [Y_W-1:0]  y_full;
  logic [OUT_W-1:0]       atan_d;
  logic [OUT_W-1:0]       atan_q;
  logic                   unused_y_hi;

  // S1: x^2 peaks at 16384 for x=-1.0, so the 16-bit signed product never wraps
  assign x_ext = S_W'($signed(atan_poly_i));
  assign sq    = x_ext * x_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      v1_q    <= 1'b0;
      val_o_q <= 1'b0;
      atan_q  <= '0;
    end else begin
      s1_q    <= sq;
      s2_q    <= s1_q;
      x1_q    <= atan_poly_i;
      x2_q    <= x1_q;
      x3_q    <= x2_q;
      v1_q    <= val_i;
      val_o_q <= v3;
      atan_q  <= atan_d;
    end
  end

  atan_poly_mac #(
    .A_W   (C_W),
    .SH    (SH_S),
    .C_VAL (C3)
  ) u_mac_s2 (
    .clk   (clk),
    .rst_n (rst_n),
    .val_i (v1_q),
    .a_i   (C5),
    .s_i   (s1_q),
    .val_o (v2),
    .acc_o (t2)
  );

  atan_poly_mac #(
    .A_W   (T_W),
    .SH    (SH_S),
    .C_VAL (C1)
  ) u_mac_s3 (
    .clk   (clk),
    .rst_n (rst_n),
    .val_i (v2),
    .a_i   (t2),
    .s_i   (s2_q),
    .val_o (v3),
    .acc_o (t3)
  );

  // S4: |y| <= 25757, so the low 16 bits carry the full result
  assign y_prod = Y_W'(t3) * Y_W'($signed(x3_q));
  assign y_full = (y_prod + Y_RND) >>> SH_X;

  assign unused_y_hi = ^y_full[Y_W-1:OUT_W];

  always_comb begin
    atan_d = atan_q;
    if (v3) begin
      atan_d = y_full[OUT_W-1:0];
    end
  end

  assign val_o       = val_o_q;
  assign atan_poly_o = atan_q;

endmodule

`default_nettype wire

// File: tb/tb_atan_poly.sv
// ============================================================================
// tb_atan_poly : scoreboard bench for atan_poly (expected values queued at issue)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_atan_poly;

  typedef struct {
    logic [15:0] v;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        val_i;
  logic [7:0]  x_i;
  logic        val_o;
  logic [15:0] y_o;

  int          cyc;
  int          checks;
  int          failures;
  logic [15:0] hold_v;
  exp_t        sb[$];
  exp_t        e_mon;
  logic        due;

  atan_poly dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .val_i       (val_i),
    .atan_poly_i (x_i),
    .val_o       (val_o),
    .atan_poly_o (y_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint fdiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [15:0] model(input logic [7:0] xc);
    longint x, s, t2, t3, y;
    x  = longint'($signed(xc));
    s  = x * x;
    t2 = -9459 + fdiv(2600 * s, 16384);
    t3 = 32616 + fdiv(t2 * s, 16384);
    y  = fdiv(t3 * x, 128);
    return y[15:0];
  endfunction

  task automatic push_exp(input logic [15:0] v);
    exp_t e;
    e.v   = v;
    e.cyc = cyc + 4;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [7:0] x, input logic [15:0] ev);
    @(posedge clk); #1;
    val_i = v;
    x_i   = x;
    if (v) push_exp(ev);
  endtask

  // Monitor: every cycle val_o must match scoreboard timing; idle cycles must hold
  always @(negedge clk) begin
    due = (sb.size() != 0) && (sb[0].cyc == cyc);
    checks++;
    if (val_o !== due) begin
      failures++;
      $display("FAIL val_o_timing cyc=%0d actual=%b required=%b", cyc, val_o, due);
    end
    if (due) begin
      e_mon = sb.pop_front();
      if (val_o === 1'b1) begin
        checks++;
        if (y_o !== e_mon.v) begin
          failures++;
          $display("FAIL atan_value cyc=%0d actual=%h required=%h", cyc, y_o, e_mon.v);
        end
      end
      hold_v = e_mon.v;
    end else if (val_o !== 1'b1) begin
      checks++;
      if (y_o !== hold_v) begin
        failures++;
        $display("FAIL atan_hold cyc=%0d actual=%h required=%h", cyc, y_o, hold_v);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // Directed vectors; -0.5 lands on -15206.5 before the final floor shift
  logic [7:0]  dir_x [5] = '{8'h00, 8'h40, 8'hC0, 8'h7F, 8'h80};
  logic [15:0] dir_y [5] = '{16'h0000, 16'h3B66, 16'hC499, 16'h6415, 16'h9B63};
  logic        bub_v [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0]  bub_x [5] = '{8'h20, 8'h55, 8'hE0, 8'h10, 8'h33};

  initial begin
    checks   = 0;
    failures = 0;
    hold_v   = 16'h0000;
    rst_n    = 1'b1;
    val_i    = 1'b1;
    x_i      = 8'h40;
    #1 rst_n = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (val_o !== 1'b0 || y_o !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state actual=%b/%h required=0/0000", val_o, y_o);
    end

    // Release with val_i already high: that sample is the first one in
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_exp(16'h3B66);

    for (int i = 0; i < 5; i++) drive(1'b1, dir_x[i], dir_y[i]);
    drive(1'b0, 8'h00, 16'h0000);
    repeat (6) @(posedge clk);

    for (int i = 0; i < 5; i++) drive(bub_v[i], bub_x[i], model(bub_x[i]));
    drive(1'b0, 8'h00, 16'h0000);
    repeat (6) @(posedge clk);

    for (int i = 0; i < 256; i++) drive(1'b1, 8'(i), model(8'(i)));
    drive(1'b0, 8'h00, 16'h0000);
    repeat (6) @(posedge clk);

    // Reset with three samples in flight
    drive(1'b1, 8'h40, 16'h3B66);
    drive(1'b1, 8'h7F, 16'h6415);
    drive(1'b1, 8'h80, 16'h9B63);
    @(posedge clk); #1;
    rst_n  = 1'b0;
    val_i  = 1'b0;
    sb.delete();
    hold_v = 16'h0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);

    drive(1'b1, 8'hC0, 16'hC499);
    drive(1'b0, 8'h00, 16'h0000);
    repeat (8) @(posedge clk);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
